// File: rtl/scp_run_ctrl.sv
// Run controller for single-cycle RISC-V cores: holds the cores in reset, runs them,
// then latches a done/pass/timeout verdict from the per-core halt/pass monitors.
module scp_run_ctrl #(
    parameter int NUM_CORES       = 1,
    parameter int RST_HOLD_CYCLES = 3,
    parameter int TIMEOUT_CYCLES  = 1000,
    parameter int CNT_W           = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [NUM_CORES-1:0] core_halt_i,
    input  logic [NUM_CORES-1:0] core_pass_i,
    output logic                 core_rst_o,
    output logic                 running_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic                 timeout_o,
    output logic [NUM_CORES-1:0] halted_mask_o,
    output logic [CNT_W-1:0]     cycle_count_o
);

    localparam int RST_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_HOLD_CYCLES - 1);
    localparam bit               TO_EN    = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] TO_LAST  = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESET = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t               state_q;
    logic [RST_W-1:0]     rst_cnt_q;
    logic [CNT_W-1:0]     cycle_count_q;
    logic [CNT_W-1:0]     cycle_count_d;
    logic [NUM_CORES-1:0] halted_q;
    logic [NUM_CORES-1:0] halted_d;
    logic [NUM_CORES-1:0] pass_cap_q;
    logic [NUM_CORES-1:0] pass_cap_d;
    logic                 all_halted;
    logic                 timeout_hit;
    logic                 core_rst_q;
    logic                 running_q;
    logic                 done_q;
    logic                 pass_q;
    logic                 timeout_q;

    // A core's pass bit is captured only on its first halt; later toggles are ignored.
    always_comb begin
        halted_d      = halted_q | core_halt_i;
        pass_cap_d    = pass_cap_q | (core_halt_i & ~halted_q & core_pass_i);
        all_halted    = &halted_d;
        cycle_count_d = (&cycle_count_q) ? cycle_count_q : cycle_count_q + CNT_W'(1);
        timeout_hit   = TO_EN && (cycle_count_q == TO_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            rst_cnt_q     <= '0;
            cycle_count_q <= '0;
            halted_q      <= '0;
            pass_cap_q    <= '0;
            core_rst_q    <= 1'b1;
            running_q     <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        state_q       <= ST_RESET;
                        rst_cnt_q     <= '0;
                        cycle_count_q <= '0;
                        halted_q      <= '0;
                        pass_cap_q    <= '0;
                        core_rst_q    <= 1'b1;
                        done_q        <= 1'b0;
                        pass_q        <= 1'b0;
                        timeout_q     <= 1'b0;
                    end
                end
                ST_RESET: begin
                    if (rst_cnt_q == RST_LAST) begin
                        state_q    <= ST_RUN;
                        core_rst_q <= 1'b0;
                        running_q  <= 1'b1;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + RST_W'(1);
                    end
                end
                ST_RUN: begin
                    halted_q      <= halted_d;
                    pass_cap_q    <= pass_cap_d;
                    cycle_count_q <= cycle_count_d;
                    // All-halted is tested first so it wins over a coincident watchdog edge.
                    if (all_halted) begin
                        state_q    <= ST_DONE;
                        core_rst_q <= 1'b1;
                        running_q  <= 1'b0;
                        done_q     <= 1'b1;
                        pass_q     <= &pass_cap_d;
                        timeout_q  <= 1'b0;
                    end else if (timeout_hit) begin
                        state_q    <= ST_DONE;
                        core_rst_q <= 1'b1;
                        running_q  <= 1'b0;
                        done_q     <= 1'b1;
                        pass_q     <= 1'b0;
                        timeout_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign core_rst_o    = core_rst_q;
    assign running_o     = running_q;
    assign done_o        = done_q;
    assign pass_o        = pass_q;
    assign timeout_o     = timeout_q;
    assign halted_mask_o = halted_q;
    assign cycle_count_o = cycle_count_q;

endmodule

// File: doc/scp_run_ctrl.md
# scp_run_ctrl

Synthesizable run controller for single-cycle RISC-V cores (SCP), parametrised over core count. It replaces fixed-delay reset/finish sequencing with a programmable reset hold, a per-core sticky halt/pass monitor, a run-cycle counter and a watchdog timeout. It sits between the top-level clock/reset and one or more SCP instances, and reports a single done/pass/timeout verdict to the bench or an on-board status port.

## Interface
- NUM_CORES, 1, number of monitored cores (≥1)
- RST_HOLD_CYCLES, 3, cycles core_rst is held high after start (≥1)
- TIMEOUT_CYCLES, 1000, RUN-cycle watchdog limit; 0 disables timeout
- CNT_W, 32, cycle counter width; must hold TIMEOUT_CYCLES

- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset of this block
- start  in  1  launch request, sampled only in IDLE and DONE
- core_halt  in  NUM_CORES  per-core halt indication (e.g. ecall/ebreak retired)
- core_pass  in  NUM_CORES  per-core pass flag, valid in the cycle its core_halt is high
- core_rst  out  1  active-high reset driven to all cores
- running  out  1  high while in RUN
- done  out  1  high in DONE
- pass  out  1  all cores halted and all captured pass bits set
- timeout  out  1  run ended by watchdog
- halted_mask  out  NUM_CORES  sticky per-core halt record
- cycle_count  out  CNT_W  RUN cycles elapsed

## Operation
- States: IDLE, RESET, RUN, DONE.
- IDLE: start=1 -> RESET; clears cycle_count, halted_mask, pass-capture mask, pass, timeout.
- RESET: internal counter; after exactly RST_HOLD_CYCLES cycles in RESET -> RUN.
- RUN: cycle_count increments each cycle (saturates at all-ones when TIMEOUT_CYCLES=0).
- Per core i, in RUN only: first cycle core_halt[i]=1 sets halted_mask[i] and captures core_pass[i]; later halt/pass changes on that core ignored. core_halt outside RUN ignored.
- RUN -> DONE when (halted_mask | core_halt) is all ones: pass = AND of captured pass bits (including this cycle's captures), timeout=0.
- RUN -> DONE on timeout when cycle_count == TIMEOUT_CYCLES-1 and not all halted: timeout=1, pass=0.
- Simultaneous all-halted and timeout edge: halt wins (timeout=0).
- DONE: verdict, halted_mask and cycle_count held; start=1 -> RESET (same clearing as from IDLE).
- start in RESET or RUN ignored.
- core_rst = 1 in IDLE, RESET, DONE; 0 only in RUN.
- running = (state==RUN); done = (state==DONE).

## Timing
- rst asserted: immediately (asynchronous) state=IDLE, core_rst=1, running=0, done=0, pass=0, timeout=0, halted_mask=0, cycle_count=0, internal counters 0.
- rst mid-RUN/RESET: same immediate clear; cores return to reset the same instant.
- start high at edge E (IDLE) -> RESET from E; RUN from edge E+RST_HOLD_CYCLES; core_rst falls after that edge.
- First RUN cycle shows cycle_count=0; at the terminating edge cycle_count becomes N = number of RUN cycles including the terminating cycle.
- Timeout run: final cycle_count = TIMEOUT_CYCLES.
- done/pass/timeout update on the same edge as the DONE transition (registered, no combinational path from core_halt).

## Test plan
- Reset: rst=1 mid-operation -> core_rst=1, done=0, pass=0, timeout=0, cycle_count=0, halted_mask=0 without waiting for a clock edge.
- NUM_CORES=1, RST_HOLD=3: start pulse -> core_rst high exactly 3 cycles after start edge; core_halt=1, core_pass=1 in 11th RUN cycle -> done=1, pass=1, timeout=0, cycle_count=11.
- NUM_CORES=2: core0 halts pass=1 at RUN cycle 5, core1 halts pass=0 at cycle 9 -> done at cycle 9, halted_mask=2'b11, pass=0; core0 pass toggling after its halt has no effect.
- TIMEOUT=20, no halts -> done=1, timeout=1, pass=0, cycle_count=20, core_rst=1 in DONE.
- TIMEOUT=20, sole core halts pass=1 in 20th RUN cycle -> timeout=0, pass=1, cycle_count=20.
- From DONE, start pulse -> verdict/mask/count cleared, full RESET+RUN sequence repeats; start during RUN -> no effect.
